// File: rtl/fitbit_display.sv
// fitbit_display
//   Picks one activity-tracker metric by MODE_SEL, saturates it to the display
//   range, converts it to BCD with a multi-cycle double-dabble FSM and drives a
//   4-digit time-multiplexed active-low seven-segment display with leading-zero
//   blanking and a decimal point for distance (tenths of a mile).
//
//   Ports:
//     CLK, RESET   system clock, synchronous active-high reset
//     MODE_SEL     0 steps, 1 distance, 2 initial activity, 3 high-activity time
//     STEP_COUNT   total steps (32-bit)
//     DISTANCE     distance in half-mile units (16-bit)
//     INIT_ACT     initial activity count (4-bit)
//     HIGH_TIME    high-activity seconds (16-bit)
//     SEG          cathodes {g,f,e,d,c,b,a}, active-low, registered
//     DP           decimal point, active-low, registered
//     AN           one-hot active-low digit enables, AN[0] rightmost, registered
//     BUSY         high while a BCD conversion is in progress
module fitbit_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  MODE_SEL,
  input  logic [31:0] STEP_COUNT,
  input  logic [15:0] DISTANCE,
  input  logic [3:0]  INIT_ACT,
  input  logic [15:0] HIGH_TIME,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [3:0]  AN,
  output logic        BUSY
);

  localparam int unsigned RCW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RCW-1:0] REF_MAX = RCW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [13:0]   cap_val_q, cap_val_d;
  logic [1:0]    cap_mode_q, cap_mode_d;
  logic [29:0]   shift_q, shift_d;      // {bcd[15:0], binary[13:0]}
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   tag_q, tag_d;          // {mode, value} of last completed conversion
  logic          tag_valid_q, tag_valid_d;
  logic          busy_q, busy_d;
  logic [15:0]   disp_bcd_q, disp_bcd_d;
  logic [1:0]    disp_mode_q, disp_mode_d;
  logic [RCW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic [13:0]   val;
  logic [18:0]   dist_x5;
  logic [29:0]   adj;
  logic [3:0]    nib;
  logic [6:0]    dec;
  logic          blank1, blank2, blank3, blank_sel;

  // Metric selection and saturation; distance product kept at 19 bits so
  // the largest input (65535 * 5) cannot wrap before the compare.
  always_comb begin
    dist_x5 = {3'b000, DISTANCE} * 19'd5;
    val     = '0;
    case (MODE_SEL)
      2'd0:    val = (STEP_COUNT > 32'd9999) ? 14'd9999 : STEP_COUNT[13:0];
      2'd1:    val = (dist_x5 > 19'd999) ? 14'd999 : dist_x5[13:0];
      2'd2:    val = {10'b0, INIT_ACT};
      default: val = (HIGH_TIME > 16'd9999) ? 14'd9999 : HIGH_TIME[13:0];
    endcase
  end

  // Conversion FSM: BUSY is registered from the next state, so it is high in
  // LOAD and all SHIFT cycles and already low in DONE.
  always_comb begin
    state_d     = state_q;
    cap_val_d   = cap_val_q;
    cap_mode_d  = cap_mode_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    disp_bcd_d  = disp_bcd_q;
    disp_mode_d = disp_mode_q;
    busy_d      = 1'b0;
    adj         = shift_q;
    case (state_q)
      S_IDLE: begin
        if (!tag_valid_q || ({MODE_SEL, val} != tag_q)) begin
          state_d    = S_LOAD;
          cap_val_d  = val;
          cap_mode_d = MODE_SEL;
          busy_d     = 1'b1;
        end
      end
      S_LOAD: begin
        shift_d = {16'b0, cap_val_q};
        cnt_d   = '0;
        state_d = S_SHIFT;
        busy_d  = 1'b1;
      end
      S_SHIFT: begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (adj[14 + 4*i +: 4] >= 4'd5)
            adj[14 + 4*i +: 4] = adj[14 + 4*i +: 4] + 4'd3;
        end
        shift_d = {adj[28:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd13)
          state_d = S_DONE;
        else
          busy_d = 1'b1;
      end
      S_DONE: begin
        disp_bcd_d  = shift_q[29:14];
        disp_mode_d = cap_mode_q;
        tag_d       = {cap_mode_q, cap_val_q};
        tag_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Refresh counter and digit index.
  always_comb begin
    ref_cnt_d = ref_cnt_q;
    idx_d     = idx_q;
    if (ref_cnt_q == REF_MAX) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end else begin
      ref_cnt_d = ref_cnt_q + 1'b1;
    end
  end

  // Digit select, blanking and segment decode feeding the output register.
  always_comb begin
    blank3 = (disp_bcd_q[15:12] == 4'd0);
    blank2 = blank3 && (disp_bcd_q[11:8] == 4'd0);
    blank1 = blank2 && (disp_bcd_q[7:4] == 4'd0) && (disp_mode_q != 2'd1);
    nib       = disp_bcd_q[3:0];
    blank_sel = 1'b0;
    case (idx_q)
      2'd0: begin nib = disp_bcd_q[3:0];   blank_sel = 1'b0;   end
      2'd1: begin nib = disp_bcd_q[7:4];   blank_sel = blank1; end
      2'd2: begin nib = disp_bcd_q[11:8];  blank_sel = blank2; end
      default: begin nib = disp_bcd_q[15:12]; blank_sel = blank3; end
    endcase
    case (nib)
      4'd0:    dec = 7'h40;
      4'd1:    dec = 7'h79;
      4'd2:    dec = 7'h24;
      4'd3:    dec = 7'h30;
      4'd4:    dec = 7'h19;
      4'd5:    dec = 7'h12;
      4'd6:    dec = 7'h02;
      4'd7:    dec = 7'h78;
      4'd8:    dec = 7'h00;
      4'd9:    dec = 7'h10;
      default: dec = 7'h7F;
    endcase
    seg_d = blank_sel ? 7'h7F : dec;
    an_d  = ~(4'b0001 << idx_q);
    dp_d  = ~((disp_mode_q == 2'd1) && (idx_q == 2'd1));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cap_val_q   <= '0;
      cap_mode_q  <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      disp_bcd_q  <= '0;
      disp_mode_q <= '0;
      ref_cnt_q   <= '0;
      idx_q       <= '0;
      seg_q       <= '1;
      dp_q        <= 1'b1;
      an_q        <= '1;
    end else begin
      state_q     <= state_d;
      cap_val_q   <= cap_val_d;
      cap_mode_q  <= cap_mode_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      busy_q      <= busy_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_mode_q <= disp_mode_d;
      ref_cnt_q   <= ref_cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign SEG  = seg_q;
  assign DP   = dp_q;
  assign AN   = an_q;
  assign BUSY = busy_q;

endmodule

// File: doc/fitbit_display.md
Name: fitbit_display

Overview:
- Downstream consumer of the activity-tracker metric outputs: step count, distance, initial-activity count, high-activity time and the 2-bit rotating display-mode select.
- Picks the metric named by the mode select and saturates it to the display range.
- Converts the value to BCD with a multi-cycle shift-add (double-dabble) FSM.
- Drives a 4-digit, time-multiplexed, active-low seven-segment display with leading-zero blanking and a decimal point for distance.

Parameters:
- REFRESH_DIV, 100000, CLK cycles per digit slot; must be >= 2. Use 4 in simulation.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- MODE_SEL  input  2  metric select: 0 steps, 1 distance, 2 initial activity, 3 high-activity time
- STEP_COUNT  input  32  total steps, unsigned
- DISTANCE  input  16  distance in half-mile units, unsigned
- INIT_ACT  input  4  initial activity count, unsigned
- HIGH_TIME  input  16  high-activity seconds, unsigned
- SEG  output  7  cathodes {g,f,e,d,c,b,a}, active-low
- DP  output  1  decimal point, active-low
- AN  output  4  digit enables, one-hot active-low; AN[0] is the rightmost digit
- BUSY  output  1  high while a BCD conversion is in progress

Behaviour:
- Reset: RESET is synchronous and active-high; clock is CLK. While RESET is high:
  - SEG=7'h7F, DP=1, AN=4'hF, BUSY=0.
  - Internal BCD register = 0, digit index = 0, refresh counter = 0, FSM = IDLE.
  - Last-converted tag is marked invalid.
- Value selection (combinational, 14-bit result V):
  - Mode 0: V = min(STEP_COUNT, 9999).
  - Mode 1: V = min(DISTANCE*5, 999), i.e. tenths of a mile. Compute in at least 19 bits before the compare.
  - Mode 2: V = INIT_ACT.
  - Mode 3: V = min(HIGH_TIME, 9999).
- Conversion trigger: in IDLE, start when {MODE_SEL,V} differs from the last-converted tag, or the tag is invalid.
  - V and MODE_SEL are captured at start. Input changes during conversion are ignored until the FSM returns to IDLE, then re-evaluated.
- FSM states: IDLE -> LOAD (1 cycle) -> SHIFT (14 cycles) -> DONE (1 cycle) -> IDLE.
  - LOAD: shift register = {16'b0, V}, BUSY=1.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift left by 1. Exit after the 14th shift.
  - DONE: copy the 16-bit BCD and captured mode into the display registers, update the tag, BUSY=0.
  - Display registers change exactly 16 cycles after the trigger cycle. The old value stays on the display until then.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1. On wrap, digit index increments 0->1->2->3->0.
  - Digit index 0 is selected on the first cycle after reset.
- Output register (all outputs registered; one-cycle latency from digit index/display registers):
  - AN = ~(4'b1 << index).
  - SEG = segment decode of the selected BCD nibble; 7'h7F when the digit is blanked.
  - Hex decode of values >9 is unreachable; drive 7'h7F if it occurs.
- Blanking: a digit is blank if it and every higher digit are zero.
  - Digit 0 is never blanked.
  - In mode 1, digit 1 is also never blanked.
- DP: 0 only when the displayed mode is 1 and index = 1; otherwise 1.
- Segment codes (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Reset mid-conversion: the FSM aborts to IDLE, and a new conversion starts on the first cycle after RESET falls.
- No other state is retained across reset.

Test Plan:
- Reset release, all inputs 0, mode 0 -> BUSY rises on cycle 2 and falls after 16 cycles. The display shows "   0": AN cycles E,D,B,7; SEG=40 on digit 0 and 7F on the others; DP=1 throughout.
- Mode 0, STEP_COUNT=12345 -> saturates to 9999. SEG=10 on all four digits, no blanking.
- Mode 1, DISTANCE=3 -> V=15, shown " 1.5". Digit0 SEG=12, digit1 SEG=79 with DP=0, digits 2–3 blank. DISTANCE=0 -> " 0.0" with DP=0 on digit1.
- Mode 2, INIT_ACT=15 -> "  15". Then switch to mode 3 with HIGH_TIME=60 -> new conversion starts; display holds "15" for 16 cycles, then shows "  60".
- During a conversion, change STEP_COUNT from 7 to 8 -> "7" is displayed first. A second conversion follows immediately after IDLE and the display ends at "8". BUSY shows two back-to-back pulses with exactly one IDLE cycle between them.
- Assert RESET for 1 cycle mid-SHIFT -> outputs reach their reset values the next cycle, and after release a fresh conversion completes with the correct BCD.
